// File: rtl/hilo_div_unit_pkg.sv
// Shared types and default sizes for the HI/LO register pair and its iterative divider.
package hilo_div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/hilo_div_unit_div_core.sv
// Unsigned restoring divider datapath: one quotient bit per i_step, operands captured on load.
module hilo_div_unit_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_load_zero,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_r
);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;

  // The remainder stays below the divisor, so the trial difference fits in WIDTH bits
  // whenever it does not borrow; the top bit is therefore the borrow flag.
  assign w_shifted = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, r_div};
  assign w_fits    = ~w_trial[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
    end else if (i_load) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_div <= i_divisor;
    end else if (i_load_zero) begin
      r_quo <= '1;
      r_rem <= i_dividend;
      r_div <= i_divisor;
    end else if (i_step) begin
      r_quo <= {r_quo[WIDTH-2:0], w_fits};
      r_rem <= w_fits ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    end
  end

  assign o_q = r_quo;
  assign o_r = r_rem;

endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO register pair with a multi-cycle DIV/DIVU engine that stalls the pipeline while busy
// and an M-stage write port for MULT/MTHI/MTLO results.
module hilo_div_unit
  import hilo_div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_startE,
  input  logic             div_signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             flushE,
  input  logic             hilowriteM,
  input  logic [WIDTH-1:0] hi_inM,
  input  logic [WIDTH-1:0] lo_inM,
  output logic             stall_div,
  output logic             div_done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  div_state_e       r_state;
  div_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_div_zero;
  logic             w_last;
  logic             w_load;
  logic             w_load_zero;
  logic             w_step;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;

  assign w_div_zero = (srcbE == '0);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_a_abs    = (div_signedE & srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign w_b_abs    = (div_signedE & srcbE[WIDTH-1]) ? -srcbE : srcbE;
  assign w_q_fin    = r_neg_q ? -w_q : w_q;
  assign w_r_fin    = r_neg_r ? -w_r : w_r;

  hilo_div_unit_div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_zero(w_load_zero),
    .i_step     (w_step),
    .i_dividend (w_load_zero ? srcaE : w_a_abs),
    .i_divisor  (w_b_abs),
    .o_q        (w_q),
    .o_r        (w_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DIV_IDLE: begin
        if (div_startE & ~flushE) begin
          w_state_next = w_div_zero ? DIV_DONE : DIV_CALC;
        end
      end
      DIV_CALC: begin
        if (flushE) begin
          w_state_next = DIV_IDLE;
        end else if (w_last) begin
          w_state_next = DIV_DONE;
        end
      end
      DIV_DONE: w_state_next = DIV_IDLE;
      default:  w_state_next = DIV_IDLE;
    endcase
  end

  always_comb begin
    stall_div   = 1'b0;
    div_done    = 1'b0;
    w_load      = 1'b0;
    w_load_zero = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        stall_div   = div_startE & ~flushE;
        w_load      = div_startE & ~flushE & ~w_div_zero;
        w_load_zero = div_startE & ~flushE & w_div_zero;
      end
      DIV_CALC: begin
        stall_div = ~flushE;
        w_step    = ~flushE;
      end
      DIV_DONE: div_done = ~flushE;
      default: ;
    endcase
  end

  // Divide-by-zero leaves Q/R exactly as preset, so its sign flags are cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      if (w_load) begin
        r_cnt   <= '0;
        r_neg_q <= div_signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
        r_neg_r <= div_signedE & srcaE[WIDTH-1];
      end else if (w_load_zero) begin
        r_cnt   <= '0;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else if (w_step) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // The divide is younger than the M-stage instruction, so its commit takes priority.
      if (div_done) begin
        r_hi <= w_r_fin;
        r_lo <= w_q_fin;
      end else if (hilowriteM) begin
        r_hi <= hi_inM;
        r_lo <= lo_inM;
      end
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: stimulus pushes expected HI/LO into a scoreboard,
// a monitor pops and compares after each div_done pulse.
module tb_hilo_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_startE;
  logic        div_signedE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        flushE;
  logic        hilowriteM;
  logic [31:0] hi_inM;
  logic [31:0] lo_inM;
  logic        stall_div;
  logic        div_done;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  typedef struct {
    int          id;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  int   n_issued = 0;

  hilo_div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .div_startE (div_startE),
    .div_signedE(div_signedE),
    .srcaE      (srcaE),
    .srcbE      (srcbE),
    .flushE     (flushE),
    .hilowriteM (hilowriteM),
    .hi_inM     (hi_inM),
    .lo_inM     (lo_inM),
    .stall_div  (stall_div),
    .div_done   (div_done),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction

  // Monitor: the committed result is visible on hi_o/lo_o in the cycle after div_done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (div_done === 1'b1) begin
        n_done++;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_div_done: got hi=0x%08h lo=0x%08h expected no commit", hi_o, lo_o);
        end else begin
          e = sb_q.pop_front();
          check("div_hi", hi_o, e.hi);
          check("div_lo", lo_o, e.lo);
          check("done_pulse_width", {31'b0, div_done}, 32'd0);
          $display("txn %0d: hi=0x%08h lo=0x%08h (exp hi=0x%08h lo=0x%08h)", e.id, hi_o, lo_o, e.hi, e.lo);
        end
      end
    end
  end

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_stall, input bit m_at_done);
    int stalls = 0;
    exp_t e;
    @(negedge clk);
    div_startE  = 1'b1;
    div_signedE = sgn;
    srcaE       = a;
    srcbE       = b;
    e.id = n_issued;
    e.hi = exp_hi;
    e.lo = exp_lo;
    sb_q.push_back(e);
    n_issued++;
    #1;
    while (stall_div === 1'b1 && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", stalls, exp_stall);
    if (m_at_done) begin
      hilowriteM = 1'b1;
      hi_inM     = 32'hAAAA0000;
      lo_inM     = 32'h00005555;
    end
    @(negedge clk);
    div_startE = 1'b0;
    hilowriteM = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    div_startE  = 1'b0;
    div_signedE = 1'b0;
    srcaE       = '0;
    srcbE       = '0;
    flushE      = 1'b0;
    hilowriteM  = 1'b0;
    hi_inM      = '0;
    lo_inM      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_hi", hi_o, 32'd0);
    check("reset_lo", lo_o, 32'd0);
    check("reset_stall", {31'b0, stall_div}, 32'd0);
    check("reset_done", {31'b0, div_done}, 32'd0);

    run_div(1'b0, 32'd100,       32'd7,        32'd2,        32'd14,       33, 1'b0);
    run_div(1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0);
    run_div(1'b1, 32'h80000000,  32'hFFFFFFFF, 32'd0,        32'h80000000, 33, 1'b0);
    run_div(1'b1, 32'd7,         32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, 1'b0);
    run_div(1'b0, 32'hFFFFFFFF,  32'd1,        32'd0,        32'hFFFFFFFF, 33, 1'b0);
    run_div(1'b0, 32'd5,         32'd0,        32'd5,        32'hFFFFFFFF, 1,  1'b0);

    // M-stage write while idle: registered, so no change until the next edge.
    @(negedge clk);
    hilowriteM = 1'b1;
    hi_inM     = 32'hAAAA0000;
    lo_inM     = 32'h00005555;
    #1;
    check("mwrite_no_bypass_hi", hi_o, 32'd5);
    @(negedge clk);
    hilowriteM = 1'b0;
    #1;
    check("mwrite_hi", hi_o, 32'hAAAA0000);
    check("mwrite_lo", lo_o, 32'h00005555);
    $display("txn mwrite: hi=0x%08h lo=0x%08h", hi_o, lo_o);

    run_div(1'b0, 32'd9, 32'd4, 32'd1, 32'd2, 33, 1'b1);

    // Flush at CALC cycle 10 of 100/7.
    @(negedge clk);
    div_startE  = 1'b1;
    div_signedE = 1'b0;
    srcaE       = 32'd100;
    srcbE       = 32'd7;
    repeat (11) @(negedge clk);
    #1;
    check("flush_pre_stall", {31'b0, stall_div}, 32'd1);
    flushE = 1'b1;
    #1;
    check("flush_stall_drop", {31'b0, stall_div}, 32'd0);
    check("flush_no_done", {31'b0, div_done}, 32'd0);
    @(negedge clk);
    flushE     = 1'b0;
    div_startE = 1'b0;
    @(negedge clk);
    #1;
    check("flush_hi_kept", hi_o, 32'd1);
    check("flush_lo_kept", lo_o, 32'd2);
    check("flush_idle_stall", {31'b0, stall_div}, 32'd0);
    $display("txn flush: hi=0x%08h lo=0x%08h", hi_o, lo_o);

    // Reset at CALC cycle 20 of 100/7.
    @(negedge clk);
    div_startE = 1'b1;
    srcaE      = 32'd100;
    srcbE      = 32'd7;
    repeat (21) @(negedge clk);
    #1;
    check("rst_pre_stall", {31'b0, stall_div}, 32'd1);
    rst        = 1'b1;
    div_startE = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_stall", {31'b0, stall_div}, 32'd0);
    check("midrst_hi", hi_o, 32'd0);
    check("midrst_lo", lo_o, 32'd0);
    $display("txn reset: hi=0x%08h lo=0x%08h", hi_o, lo_o);

    run_div(1'b0, 32'd8, 32'd2, 32'd0, 32'd4, 33, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    check("done_pulse_count", n_done, 32'd8);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
